// File: rtl/scr1_ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the SRAM responder.
// Also holds the byte-lane enable helper used by the write path.
package scr1_ahb_sram_slave_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

  localparam logic SCR1_HRESP_OKAY  = 1'b0;
  localparam logic SCR1_HRESP_ERROR = 1'b1;

  localparam logic [2:0] SCR1_HSIZE_8_BIT  = 3'd0;
  localparam logic [2:0] SCR1_HSIZE_16_BIT = 3'd1;
  localparam logic [2:0] SCR1_HSIZE_32_BIT = 3'd2;

  typedef enum logic [1:0] {
    SCR1_SRAM_FSM_IDLE,
    SCR1_SRAM_FSM_DATA,
    SCR1_SRAM_FSM_ERR1,
    SCR1_SRAM_FSM_ERR2
  } type_scr1_ahb_sram_fsm_e;

  // Little-endian lane enables; size is already known to be legal here.
  function automatic logic [3:0] scr1_ahb_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SCR1_HSIZE_8_BIT[1:0]:  be = 4'b0001 << a;
      SCR1_HSIZE_16_BIT[1:0]: be = a[1] ? 4'b1100 : 4'b0011;
      default:                be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/scr1_ahb_sram_array.sv
// Word array with byte-enable write and combinational read.
// Kept behind this boundary so a vendor RAM wrapper can replace it.
module scr1_ahb_sram_array #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/scr1_ahb_sram_slave.sv
// AHB-Lite SRAM responder: address-phase capture, legality decode, wait-state
// rotator and two-cycle ERROR response in front of a word array.
module scr1_ahb_sram_slave
  import scr1_ahb_sram_slave_pkg::*;
#(
  parameter int          SCR1_MEM_POWER_SIZE = 16,
  parameter logic [31:0] SCR1_STALL_RST      = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               stall_pattern,
  input  logic                      stall_load,
  input  logic [1:0]                htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] haddr,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [SCR1_AHB_WIDTH-1:0] hwdata,
  output logic                      hready,
  output logic [SCR1_AHB_WIDTH-1:0] hrdata,
  output logic                      hresp
);

  localparam int SZ = SCR1_MEM_POWER_SIZE;

  // An all-zero pattern would stall forever, so it is promoted to zero-wait.
  function automatic logic [31:0] fix_pat(input logic [31:0] p);
    return (p == '0) ? '1 : p;
  endfunction

  type_scr1_ahb_sram_fsm_e state_q, state_d;
  logic [31:0]             rot_q, rot_d;
  logic [SZ-1:0]           addr_q, addr_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;

  logic                      accept, legal, done, we;
  logic [SCR1_AHB_WIDTH-1:0] rdata;

  assign legal = ((haddr >> SZ) == '0) && (hsize <= SCR1_HSIZE_32_BIT)
              && !((hsize == SCR1_HSIZE_16_BIT) && haddr[0])
              && !((hsize == SCR1_HSIZE_32_BIT) && (haddr[1:0] != 2'b00));

  always_comb begin
    hready = 1'b1;
    hresp  = SCR1_HRESP_OKAY;
    case (state_q)
      SCR1_SRAM_FSM_DATA: hready = rot_q[0];
      SCR1_SRAM_FSM_ERR1: begin hready = 1'b0; hresp = SCR1_HRESP_ERROR; end
      SCR1_SRAM_FSM_ERR2: hresp = SCR1_HRESP_ERROR;
      default: ;
    endcase
    done   = (state_q == SCR1_SRAM_FSM_DATA) && rot_q[0];
    accept = hready && ((htrans == SCR1_HTRANS_NONSEQ) || (htrans == SCR1_HTRANS_SEQ));
    hrdata = (done && !write_q) ? rdata : '0;
    we     = done && write_q && !rst;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    // Any cycle with hready high ends the current data phase and samples the bus.
    if (hready) begin
      state_d = SCR1_SRAM_FSM_IDLE;
      if (accept) begin
        addr_d  = haddr[SZ-1:0];
        write_d = hwrite;
        size_d  = hsize[1:0];
        state_d = legal ? SCR1_SRAM_FSM_DATA : SCR1_SRAM_FSM_ERR1;
      end
    end else if (state_q == SCR1_SRAM_FSM_ERR1) begin
      state_d = SCR1_SRAM_FSM_ERR2;
    end
    if (stall_load)                       rot_d = fix_pat(stall_pattern);
    else if (state_q == SCR1_SRAM_FSM_DATA) rot_d = {rot_q[0], rot_q[31:1]};
    else                                  rot_d = rot_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCR1_SRAM_FSM_IDLE;
      rot_q   <= fix_pat(SCR1_STALL_RST);
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  scr1_ahb_sram_array #(
    .AW (SZ-2),
    .DW (SCR1_AHB_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .be    (scr1_ahb_be(size_q, addr_q[1:0])),
    .addr  (addr_q[SZ-1:2]),
    .wdata (hwdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_scr1_ahb_sram_slave.sv
// Directed table-driven bench for the AHB SRAM responder, plus hand-written
// reset-in-flight and pipelined write/read sequences.
module tb_scr1_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stall_pattern;
  logic        stall_load;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_ahb_sram_slave dut (
    .clk(clk), .rst(rst), .stall_pattern(stall_pattern), .stall_load(stall_load),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata), .hresp(hresp)
  );

  typedef struct {
    logic        ld;
    logic [31:0] pat;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_waits;
    logic        exp_resp;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Single non-pipelined transfer; returns just after the edge that ends it.
  task automatic xfer(input string nm, input vec_t v);
    int n = 0;
    logic r0 = 1'b0, rl = 1'b0;
    logic [31:0] rd = '0;
    if (v.ld) begin
      stall_load = 1'b1; stall_pattern = v.pat;
      @(posedge clk); #1;
      stall_load = 1'b0;
    end
    htrans = 2'b10; haddr = v.addr; hwrite = v.wr; hsize = v.size;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = v.wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) r0 = hresp;
      if (hready) begin rd = hrdata; rl = hresp; break; end
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk({nm, " waits"}, n, v.exp_waits);
    chk({nm, " resp_first"}, {31'b0, r0}, {31'b0, v.exp_resp});
    chk({nm, " resp_last"}, {31'b0, rl}, {31'b0, v.exp_resp});
    chk({nm, " rdata"}, rd, v.exp_rd);
  endtask

  initial begin
    int n;
    vec_t v;
    //           ld    pat            wr    addr           sz    wdata          exp_rd        w  resp
    vt[0]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 32'h0,         0, 1'b0};
    vt[1]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'hDEAD_BEEF, 0, 1'b0};
    vt[2]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 3'd2, 32'h00EF_0000, 32'h0,         0, 1'b0};
    vt[3]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0103, 3'd0, 32'h5A00_0000, 32'h0,         0, 1'b0};
    vt[4]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 3'd1, 32'h0000_1234, 32'h0,         0, 1'b0};
    vt[5]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h5AEF_1234, 0, 1'b0};
    vt[6]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0102, 3'd2, 32'h0,         32'h0,         1, 1'b1};
    vt[7]  = '{1'b0, 32'h0,         1'b0, 32'h0001_0000, 3'd2, 32'h0,         32'h0,         1, 1'b1};
    vt[8]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0101, 3'd1, 32'hFFFF_FFFF, 32'h0,         1, 1'b1};
    vt[9]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 3'd3, 32'hFFFF_FFFF, 32'h0,         1, 1'b1};
    vt[10] = '{1'b0, 32'h0,         1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h5AEF_1234, 0, 1'b0};
    vt[11] = '{1'b0, 32'h0,         1'b0, 32'h0000_0102, 3'd1, 32'h0,         32'h5AEF_1234, 0, 1'b0};
    vt[12] = '{1'b1, 32'hFFFF_FFFA, 1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h5AEF_1234, 1, 1'b0};
    vt[13] = '{1'b0, 32'h0,         1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h5AEF_1234, 1, 1'b0};
    vt[14] = '{1'b0, 32'h0,         1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h5AEF_1234, 0, 1'b0};
    vt[15] = '{1'b1, 32'h0,         1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h5AEF_1234, 0, 1'b0};
    vt[16] = '{1'b1, 32'hFFFF_FFF0, 1'b1, 32'h0000_0104, 3'd2, 32'h7654_3210, 32'h0,         4, 1'b0};
    vt[17] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0104, 3'd2, 32'h0,         32'h7654_3210, 0, 1'b0};

    rst = 1'b1; stall_pattern = '0; stall_load = 1'b0;
    htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    @(posedge clk); @(negedge clk);
    chk("reset hready", {31'b0, hready}, 32'd1);
    chk("reset hresp", {31'b0, hresp}, 32'd0);
    chk("reset hrdata", hrdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) xfer($sformatf("vec%0d", i), vt[i]);

    // Reset while a stalled write is pending: the write must be dropped.
    v = '{1'b0, 32'h0, 1'b1, 32'h40, 3'd2, 32'hCAFE_F00D, 32'h0, 0, 1'b0};
    xfer("rst_pre_write", v);
    stall_load = 1'b1; stall_pattern = 32'hFFFF_0000;
    @(posedge clk); #1;
    stall_load = 1'b0;
    htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'h1111_1111;
    @(negedge clk);
    chk("rst_stall hready", {31'b0, hready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after hready", {31'b0, hready}, 32'd1);
    chk("rst_after hresp", {31'b0, hresp}, 32'd0);
    chk("rst_after hrdata", hrdata, 32'h0);
    @(posedge clk); #1;
    v = '{1'b0, 32'h0, 1'b0, 32'h40, 3'd2, 32'h0, 32'hCAFE_F00D, 0, 1'b0};
    xfer("rst_readback", v);

    // Pipelined W then R to the same word with alternating wait states.
    stall_load = 1'b1; stall_pattern = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    stall_load = 1'b0;
    htrans = 2'b10; haddr = 32'h200; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'h0BAD_CAFE; hwrite = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hready) break;
      n++;
      @(posedge clk); #1;
    end
    chk("b2b write waits", n, 32'd1);
    @(posedge clk); #1;
    htrans = 2'b00;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hready) break;
      n++;
      @(posedge clk); #1;
    end
    chk("b2b read waits", n, 32'd1);
    chk("b2b read data", hrdata, 32'h0BAD_CAFE);
    chk("b2b read resp", {31'b0, hresp}, 32'd0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
